// File: rtl/stream_layer_ctrl_pkg.sv
// Shared types and constants for the streamline layer controller.
// Holds the FSM state enum, default parameters and the slot-width helper.
package stream_layer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_N_LAYERS    = 2;
    localparam int DEF_STAGE_LEN   = 16;
    localparam int DEF_NUM_BATCH_W = 8;

    // Slot counter must reach nb_q + N_LAYERS - 1 without overflow.
    function automatic int slot_w(input int nbw, input int nl);
        return nbw + $clog2(nl) + 1;
    endfunction

endpackage

// File: rtl/stream_layer_ctrl_if.sv
// Control/status bundle between the top level and the layer controller.
// master: start_i, num_batch_i, stall_i out; enables, clears, busy/done, stall_cnt in.
interface stream_layer_ctrl_if
    import stream_layer_ctrl_pkg::*;
#(
    parameter int N_LAYERS    = DEF_N_LAYERS,
    parameter int NUM_BATCH_W = DEF_NUM_BATCH_W
);
    logic                   start_i;
    logic [NUM_BATCH_W-1:0] num_batch_i;
    logic                   stall_i;
    logic [N_LAYERS-1:0]    local_en_o;
    logic [N_LAYERS-1:0]    clear_local_o;
    logic                   busy_o;
    logic                   done_o;
    logic [31:0]            stall_cnt_o;

    modport master (
        output start_i, num_batch_i, stall_i,
        input  local_en_o, clear_local_o, busy_o, done_o, stall_cnt_o
    );

    modport slave (
        input  start_i, num_batch_i, stall_i,
        output local_en_o, clear_local_o, busy_o, done_o, stall_cnt_o
    );
endinterface

// File: rtl/stream_layer_ctrl_layer_window_dec.sv
// Wavefront window decode: layer k is active while slot-k lies in [0, nb_q).
// Ports: i_state/i_slot/i_cyc/i_nb/i_stall in; o_en/o_clr per-layer out.
module layer_window_dec
    import stream_layer_ctrl_pkg::*;
#(
    parameter int N_LAYERS    = DEF_N_LAYERS,
    parameter int STAGE_LEN   = DEF_STAGE_LEN,
    parameter int NUM_BATCH_W = DEF_NUM_BATCH_W,
    parameter int SLOT_W      = slot_w(NUM_BATCH_W, N_LAYERS),
    parameter int CYC_W       = $clog2(STAGE_LEN)
) (
    input  state_t                 i_state,
    input  logic [SLOT_W-1:0]      i_slot,
    input  logic [CYC_W-1:0]       i_cyc,
    input  logic [NUM_BATCH_W-1:0] i_nb,
    input  logic                   i_stall,
    output logic [N_LAYERS-1:0]    o_en,
    output logic [N_LAYERS-1:0]    o_clr
);
    logic              w_run;
    logic              w_cyc0;
    logic [SLOT_W-1:0] w_nb;

    assign w_run  = (i_state == ST_RUN);
    assign w_cyc0 = (i_cyc == '0);
    assign w_nb   = SLOT_W'(i_nb);

    for (genvar k = 0; k < N_LAYERS; k++) begin : g_layer
        localparam logic [SLOT_W-1:0] K = SLOT_W'(k);
        logic w_act;
        assign w_act    = w_run && (i_slot >= K) && ((i_slot - K) < w_nb);
        assign o_en[k]  = w_act && !i_stall;
        // A clear held off by a stall at cyc 0 fires on the first free cycle.
        assign o_clr[k] = o_en[k] && w_cyc0;
    end
endmodule

// File: rtl/stream_layer_ctrl.sv
// Global controller for the layer-pipelined datapath (IDLE/RUN/DONE FSM).
// Ports: clk_i, rstn_i, bus (slave). Optional stall counter: STREAM_LAYER_CTRL_PERF_EN.
module stream_layer_ctrl
    import stream_layer_ctrl_pkg::*;
#(
    parameter int N_LAYERS    = DEF_N_LAYERS,
    parameter int STAGE_LEN   = DEF_STAGE_LEN,
    parameter int NUM_BATCH_W = DEF_NUM_BATCH_W
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    stream_layer_ctrl_if.slave bus
);
    localparam int SLOT_W = slot_w(NUM_BATCH_W, N_LAYERS);
    localparam int CYC_W  = $clog2(STAGE_LEN);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(STAGE_LEN - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CYC_W-1:0]       r_cyc;
    logic [SLOT_W-1:0]      r_slot;
    logic [NUM_BATCH_W-1:0] r_nb;
    logic [SLOT_W-1:0]      w_slot_last;
    logic                   w_accept;
    logic                   w_adv;
    logic                   w_wrap;
    logic                   w_final;

    assign w_accept = (r_state == ST_IDLE) && bus.start_i;
    assign w_adv    = (r_state == ST_RUN) && !bus.stall_i;
    assign w_wrap   = (r_cyc == CYC_LAST);
    // Last slot index = nb_q + N_LAYERS - 2; modular add covers N_LAYERS=1.
    assign w_slot_last = SLOT_W'(r_nb) + SLOT_W'(N_LAYERS - 2);
    assign w_final  = w_adv && w_wrap && (r_slot == w_slot_last);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start_i)
                    w_state_nxt = (bus.num_batch_i == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN:  if (w_final) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cyc  <= '0;
            r_slot <= '0;
            r_nb   <= '0;
        end else if (w_accept) begin
            r_cyc  <= '0;
            r_slot <= '0;
            r_nb   <= bus.num_batch_i;
        end else if (w_adv) begin
            if (w_wrap) begin
                r_cyc  <= '0;
                r_slot <= r_slot + 1'b1;
            end else begin
                r_cyc  <= r_cyc + 1'b1;
            end
        end
    end

    assign bus.busy_o = (r_state == ST_RUN);
    assign bus.done_o = (r_state == ST_DONE);

    layer_window_dec #(
        .N_LAYERS    (N_LAYERS),
        .STAGE_LEN   (STAGE_LEN),
        .NUM_BATCH_W (NUM_BATCH_W),
        .SLOT_W      (SLOT_W),
        .CYC_W       (CYC_W)
    ) u_win (
        .i_state (r_state),
        .i_slot  (r_slot),
        .i_cyc   (r_cyc),
        .i_nb    (r_nb),
        .i_stall (bus.stall_i),
        .o_en    (bus.local_en_o),
        .o_clr   (bus.clear_local_o)
    );

`ifdef STREAM_LAYER_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_stall_cnt <= '0;
        else if (w_accept)
            r_stall_cnt <= '0;
        else if ((r_state == ST_RUN) && bus.stall_i && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign bus.stall_cnt_o = r_stall_cnt;
`else
    assign bus.stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_stream_layer_ctrl.sv
// Directed bench for stream_layer_ctrl: basic, zero batch, stall, ignored start,
// async reset mid-run and a deep 4-layer configuration.
module tb_stream_layer_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    stream_layer_ctrl_if #(.N_LAYERS(2), .NUM_BATCH_W(8)) b2();
    stream_layer_ctrl_if #(.N_LAYERS(4), .NUM_BATCH_W(8)) b4();

    stream_layer_ctrl #(.N_LAYERS(2), .STAGE_LEN(4), .NUM_BATCH_W(8)) dut2 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (b2)
    );

    stream_layer_ctrl #(.N_LAYERS(4), .STAGE_LEN(2), .NUM_BATCH_W(8)) dut4 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (b4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] obs2();
        return {b2.busy_o, b2.done_o, b2.local_en_o, b2.clear_local_o};
    endfunction

    function automatic logic [9:0] obs4();
        return {b4.busy_o, b4.done_o, b4.local_en_o, b4.clear_local_o};
    endfunction

    // Caller is at #1 after an edge: that cycle is cycle 0 (start asserted).
    task automatic run_basic(input bit stl, input bit ign);
        int s;
        int e;
        bit st;
        logic [1:0] en;
        logic [1:0] cl;
        logic bz;
        logic dn;
        s = stl ? 3 : 0;
        b2.start_i = 1'b1;
        b2.num_batch_i = 8'd3;
        b2.stall_i = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            tick();
            b2.start_i = ign && (c == 6);
            b2.num_batch_i = (ign && c == 6) ? 8'd9 : 8'd3;
            st = stl && (c >= 5) && (c <= 7);
            b2.stall_i = st;
            #1;
            e = (c > 7) ? c - s : c;
            en[0] = !st && (e >= 1) && (e <= 12);
            en[1] = !st && (e >= 5) && (e <= 16);
            cl[0] = !st && (e == 1 || e == 5 || e == 9);
            cl[1] = !st && (e == 5 || e == 9 || e == 13);
            bz = (c <= 16 + s);
            dn = (c == 17 + s);
            chk($sformatf("run%0d%0d_c%0d", stl, ign, c),
                64'(obs2()), 64'({bz, dn, en, cl}));
        end
    endtask

    initial begin
        b2.start_i = 1'b0;
        b2.num_batch_i = '0;
        b2.stall_i = 1'b0;
        b4.start_i = 1'b0;
        b4.num_batch_i = '0;
        b4.stall_i = 1'b0;

        #12;
        chk("reset2", 64'(obs2()), 64'd0);
        chk("reset4", 64'(obs4()), 64'd0);
        chk("reset_cnt", 64'(b2.stall_cnt_o), 64'd0);
        rstn = 1'b1;
        tick();
        tick();
        chk("idle2", 64'(obs2()), 64'd0);

        // Basic run
        run_basic(1'b0, 1'b0);

        // Zero batch
        b2.start_i = 1'b1;
        b2.num_batch_i = 8'd0;
        tick();
        b2.start_i = 1'b0;
        #1;
        chk("zero_c1", 64'(obs2()), 64'(6'b010000));
        tick();
        #1;
        chk("zero_c2", 64'(obs2()), 64'd0);

        // Stall run
        run_basic(1'b1, 1'b0);
`ifdef STREAM_LAYER_CTRL_PERF_EN
        chk("stall_cnt", 64'(b2.stall_cnt_o), 64'd3);
`else
        chk("stall_cnt", 64'(b2.stall_cnt_o), 64'd0);
`endif

        // Ignored start during RUN
        run_basic(1'b0, 1'b1);
        chk("cnt_clr", 64'(b2.stall_cnt_o), 64'd0);

        // Reset mid-run
        b2.start_i = 1'b1;
        b2.num_batch_i = 8'd3;
        for (int c = 1; c <= 7; c++) begin
            tick();
            b2.start_i = 1'b0;
        end
        #1;
        chk("pre_rst_c7", 64'(obs2()), 64'(6'b101100));
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_async", 64'(obs2()), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            chk($sformatf("rst_hold%0d", c), 64'(obs2()), 64'd0);
        end
        rstn = 1'b1;
        tick();
        run_basic(1'b0, 1'b0);

        // Deep configuration: 4 layers, 2-cycle slots, one vector
        b4.start_i = 1'b1;
        b4.num_batch_i = 8'd1;
        for (int c = 1; c <= 10; c++) begin
            logic [3:0] en;
            logic [3:0] cl;
            tick();
            b4.start_i = 1'b0;
            #1;
            for (int k = 0; k < 4; k++) begin
                en[k] = (c == 2 * k + 1) || (c == 2 * k + 2);
                cl[k] = (c == 2 * k + 1);
            end
            chk($sformatf("deep_c%0d", c), 64'(obs4()),
                64'({(c <= 8), (c == 9), en, cl}));
        end
        chk("deep_cnt", 64'(b4.stall_cnt_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_layer_ctrl.md
Name: stream_layer_ctrl

Overview:
Parametrised global controller for the streamline (layer-pipelined) datapath. It generalises the fixed two-layer controller to N_LAYERS stages and a runtime batch count. Input vectors flow through the layers in a wavefront: layer k works on vector b during slot s = b + k. It drives per-layer enable and clear strobes, honours a global stall, and reports busy/done to the top level.

Parameters:
N_LAYERS, 2, number of pipelined layers (>=1)
STAGE_LEN, 16, cycles per slot (per-layer compute length for one vector, >=2)
NUM_BATCH_W, 8, width of runtime batch count

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
start_i  in  1  start pulse; sampled only in IDLE
num_batch_i  in  NUM_BATCH_W  vectors to process; latched on accepted start
stall_i  in  1  freezes all counters while high (downstream not ready)
local_en_o  out  N_LAYERS  per-layer compute enable
clear_local_o  out  N_LAYERS  per-layer accumulator clear, first cycle of an active slot
busy_o  out  1  high in RUN
done_o  out  1  one-cycle pulse at end of operation
stall_cnt_o  out  32  stalled RUN cycles (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk_i. Reset rstn_i is asynchronous, active-low.
- States: IDLE, RUN, DONE.
- Reset values: state IDLE; all counters 0. All outputs 0.
- IDLE to RUN: start_i high at edge t. num_batch_i is latched into nb_q. RUN begins at cycle t+1 with slot=0 and cyc=0.
- IDLE to DONE: start_i high with num_batch_i==0. No enables are issued. done_o pulses at t+1.
- Counters:
  - cyc counts 0..STAGE_LEN-1. On wrap, slot increments.
  - TOTAL = nb_q + N_LAYERS - 1 slots.
  - On the RUN cycle with slot==TOTAL-1 and cyc==STAGE_LEN-1 and no stall, move to DONE.
  - Slot counter width is NUM_BATCH_W + clog2(N_LAYERS) + 1.
- DONE lasts one cycle: done_o=1, then IDLE.
- Window: act[k] = RUN && (slot >= k) && (slot - k < nb_q).
- local_en_o[k] = act[k] && !stall_i. This is combinational from registered state plus stall_i.
- clear_local_o[k] = local_en_o[k] && cyc==0. If stalled at cyc 0, the clear is deferred to the first unstalled cycle.
- Stall: stall_i high in RUN freezes cyc and slot. stall_i is ignored in IDLE/DONE, and it delays the RUN-to-DONE transition.
- busy_o = (state==RUN).
- start_i in RUN or DONE is ignored; the latched nb_q is unaffected.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no done pulse.
- Latency for a stall-free run: nb_q=B gives B+N_LAYERS-1 slots of STAGE_LEN cycles. done_o asserts (B+N_LAYERS-1)*STAGE_LEN + 1 cycles after start.

Optional Feature:
- Macro STREAM_LAYER_CTRL_PERF_EN.
- Defined:
  - A 32-bit stall_cnt_o increments on every RUN cycle with stall_i=1.
  - It saturates at all-ones and clears on an accepted start.
  - Its value holds after done.
- Undefined: stall_cnt_o is tied to 0 and no counter logic is built.

Decomposition:
- Package stream_layer_ctrl_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default constants for N_LAYERS, STAGE_LEN, NUM_BATCH_W;
  - a clog2-based width helper for the slot counter.
- One sub-module, layer_window_dec: pure decode of slot, cyc, nb_q, stall_i and state into local_en_o/clear_local_o. It is instantiated once and is vector-wide over N_LAYERS.

Test Plan:
- Basic run. N_LAYERS=2, STAGE_LEN=4, num_batch_i=3, start at cycle 0:
  - local_en_o[0] high cycles 1-12, local_en_o[1] high cycles 5-16;
  - clear_local_o[0] at 1,5,9 and clear_local_o[1] at 5,9,13;
  - done_o at 17 only; busy_o cycles 1-16.
- Zero batch. num_batch_i=0 start at cycle 0 -> done_o pulse at cycle 1; local_en_o never asserted; busy_o stays 0.
- Stall. Basic run with stall_i high cycles 5-7:
  - local_en_o=0 during stall;
  - clear_local_o[1] and clear_local_o[0] for slot 1 move to cycle 8;
  - done_o at cycle 20;
  - with PERF_EN, stall_cnt_o=3.
- Ignored start. start_i pulse at cycle 6 with num_batch_i=9 during the basic run -> timing identical to the basic run; done_o at 17.
- Reset mid-run. rstn_i low at cycle 7 (asynchronous, mid-cycle):
  - all outputs 0 immediately; no done_o;
  - a new start after release gives a fresh full sequence from slot 0.
- Deep config. N_LAYERS=4, STAGE_LEN=2, num_batch_i=1:
  - local_en_o[k] high cycles 2k+1..2k+2;
  - done_o at cycle 9.
